// File: rtl/pc_pkg.sv
// Shared types and default constants for the IF-stage program-counter generator.
package pc_pkg;

    localparam int          XLEN_DEF         = 32;
    localparam int          INC_DEF          = 4;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0180;

    // Encoding order matters: a larger value is a stronger redirect.
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        JUMP   = 2'd1,
        BRANCH = 2'd2,
        EXC    = 2'd3
    } prio_e;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    function automatic prio_e redirect_prio(input logic exc, input logic branch, input logic jump);
        if (exc)         return EXC;
        else if (branch) return BRANCH;
        else if (jump)   return JUMP;
        else             return NONE;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch/redirect bundle between pc_gen (master) and the surrounding pipeline (slave).
// The misalign_o signal exists only when PC_GEN_ALIGN_CHECK_EN is defined.
interface pc_gen_if #(
    parameter int XLEN = 32
);

    logic            stall_i;
    logic            fetch_ready_i;
    logic            jump_i;
    logic [XLEN-1:0] jump_target_i;
    logic            branch_i;
    logic [XLEN-1:0] branch_target_i;
    logic            exc_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus_o;
    logic            fetch_valid_o;
    logic            pending_o;
`ifdef PC_GEN_ALIGN_CHECK_EN
    logic            misalign_o;
`endif

    modport master (
        input  stall_i, fetch_ready_i, jump_i, jump_target_i,
        input  branch_i, branch_target_i, exc_i,
`ifdef PC_GEN_ALIGN_CHECK_EN
        output misalign_o,
`endif
        output pc_o, pc_plus_o, fetch_valid_o, pending_o
    );

    modport slave (
        output stall_i, fetch_ready_i, jump_i, jump_target_i,
        output branch_i, branch_target_i, exc_i,
`ifdef PC_GEN_ALIGN_CHECK_EN
        input  misalign_o,
`endif
        input  pc_o, pc_plus_o, fetch_valid_o, pending_o
    );

endinterface

// File: rtl/pc_redirect_buf.sv
// Single-entry buffer for a redirect that arrives while fetch cannot advance.
// Tracks a misalignment tag alongside the target when PC_GEN_ALIGN_CHECK_EN is defined.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_adv,
    input  prio_e           i_req_prio,
    input  logic [XLEN-1:0] i_req_target,
`ifdef PC_GEN_ALIGN_CHECK_EN
    input  logic            i_req_misalign,
    output logic            o_misalign,
`endif
    output logic            o_pending,
    output prio_e           o_prio,
    output logic [XLEN-1:0] o_target
);

    prio_e           r_prio;
    logic [XLEN-1:0] r_target;
    logic            w_load;
`ifdef PC_GEN_ALIGN_CHECK_EN
    logic            r_misalign;
`endif

    // A weaker redirect never displaces a stronger one already waiting.
    assign w_load = !i_adv && (i_req_prio != NONE) && (i_req_prio >= r_prio);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio     <= NONE;
            r_target   <= '0;
`ifdef PC_GEN_ALIGN_CHECK_EN
            r_misalign <= 1'b0;
`endif
        end else if (i_adv) begin
            r_prio     <= NONE;
            r_target   <= '0;
`ifdef PC_GEN_ALIGN_CHECK_EN
            r_misalign <= 1'b0;
`endif
        end else if (w_load) begin
            r_prio     <= i_req_prio;
            r_target   <= i_req_target;
`ifdef PC_GEN_ALIGN_CHECK_EN
            r_misalign <= i_req_misalign;
`endif
        end
    end

    assign o_pending = (r_prio != NONE);
    assign o_prio    = r_prio;
    assign o_target  = r_target;
`ifdef PC_GEN_ALIGN_CHECK_EN
    assign o_misalign = r_misalign;
`endif

endmodule

// File: rtl/pc_gen.sv
// IF-stage program-counter generator: fetch handshake, redirect priority, next-PC selection.
// Optional target alignment checking is enabled with PC_GEN_ALIGN_CHECK_EN.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter int              INC          = INC_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(EXC_VECTOR_DEF)
) (
    input logic     clk,
    input logic     rst_n,
    pc_gen_if.master bus
);

    localparam logic [XLEN-1:0] INC_W    = XLEN'(INC);
    localparam logic [XLEN-1:0] LOW_MASK = INC_W - XLEN'(1);

    state_e          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_valid;

    logic            w_adv;
    prio_e           w_new_prio;
    logic [XLEN-1:0] w_raw_target;
    logic [XLEN-1:0] w_new_target;
    logic            w_take_pending;
    logic [XLEN-1:0] w_next_pc;
    logic            w_buf_pending;
    prio_e           w_buf_prio;
    logic [XLEN-1:0] w_buf_target;
`ifdef PC_GEN_ALIGN_CHECK_EN
    logic            r_misalign;
    logic            w_new_misalign;
    logic            w_next_misalign;
    logic            w_buf_misalign;
`endif

    assign w_adv      = r_valid & bus.fetch_ready_i & ~bus.stall_i;
    assign w_new_prio = redirect_prio(bus.exc_i, bus.branch_i, bus.jump_i);

    always_comb begin
        w_raw_target = '0;
        case (w_new_prio)
            EXC:     w_raw_target = EXC_VECTOR;
            BRANCH:  w_raw_target = bus.branch_target_i;
            JUMP:    w_raw_target = bus.jump_target_i;
            default: w_raw_target = '0;
        endcase
`ifdef PC_GEN_ALIGN_CHECK_EN
        w_new_misalign = ((w_new_prio == BRANCH) || (w_new_prio == JUMP)) &&
                         (|(w_raw_target & LOW_MASK));
        w_new_target   = w_new_misalign ? (EXC_VECTOR & ~LOW_MASK) : (w_raw_target & ~LOW_MASK);
`else
        w_new_target   = w_raw_target & ~LOW_MASK;
`endif
    end

    pc_redirect_buf #(
        .XLEN (XLEN)
    ) u_buf (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_adv          (w_adv),
        .i_req_prio     (w_new_prio),
        .i_req_target   (w_new_target),
`ifdef PC_GEN_ALIGN_CHECK_EN
        .i_req_misalign (w_new_misalign),
        .o_misalign     (w_buf_misalign),
`endif
        .o_pending      (w_buf_pending),
        .o_prio         (w_buf_prio),
        .o_target       (w_buf_target)
    );

    // Only a buffered exception outranks a fresh redirect arriving with the advance.
    assign w_take_pending = w_buf_pending &&
                            ((w_new_prio == NONE) || ((w_buf_prio == EXC) && (w_new_prio != EXC)));

    always_comb begin
        w_next_pc = r_pc + INC_W;
`ifdef PC_GEN_ALIGN_CHECK_EN
        w_next_misalign = 1'b0;
`endif
        if (w_take_pending) begin
            w_next_pc = w_buf_target;
`ifdef PC_GEN_ALIGN_CHECK_EN
            w_next_misalign = w_buf_misalign;
`endif
        end else if (w_new_prio != NONE) begin
            w_next_pc = w_new_target;
`ifdef PC_GEN_ALIGN_CHECK_EN
            w_next_misalign = w_new_misalign;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= BOOT;
            r_pc       <= RESET_VECTOR;
            r_valid    <= 1'b0;
`ifdef PC_GEN_ALIGN_CHECK_EN
            r_misalign <= 1'b0;
`endif
        end else begin
`ifdef PC_GEN_ALIGN_CHECK_EN
            r_misalign <= w_adv & w_next_misalign;
`endif
            case (r_state)
                BOOT: begin
                    r_state <= RUN;
                    r_valid <= 1'b1;
                end
                RUN: begin
                    if (!w_adv) r_state <= HOLD;
                end
                HOLD: begin
                    if (w_adv) r_state <= RUN;
                end
                default: begin
                    r_state <= BOOT;
                    r_valid <= 1'b0;
                end
            endcase
            if (w_adv) r_pc <= w_next_pc;
        end
    end

    assign bus.pc_o          = r_pc;
    assign bus.pc_plus_o     = r_pc + INC_W;
    assign bus.fetch_valid_o = r_valid;
    assign bus.pending_o     = w_buf_pending;
`ifdef PC_GEN_ALIGN_CHECK_EN
    assign bus.misalign_o    = r_misalign;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed vectors push expected post-edge state, a monitor pops and compares.
// Alignment-check expectations follow PC_GEN_ALIGN_CHECK_EN.
module tb_pc_gen;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [31:0] pcPlus;
        logic        valid;
        logic        pend;
        logic        mis;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   vecId;
    exp_t expQ[$];

    pc_gen_if #(.XLEN(32)) bus ();

    pc_gen #(
        .XLEN         (32),
        .INC          (4),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h0000_0180)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    logic actMis;
`ifdef PC_GEN_ALIGN_CHECK_EN
    assign actMis = bus.misalign_o;
    localparam logic [31:0] ALIGN_PC   = 32'h0000_0180;
    localparam logic        ALIGN_MIS  = 1'b1;
`else
    assign actMis = 1'b0;
    localparam logic [31:0] ALIGN_PC   = 32'h0000_0100;
    localparam logic        ALIGN_MIS  = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input exp_t e);
        checks++;
        if (bus.pc_o !== e.pc || bus.pc_plus_o !== e.pcPlus || bus.fetch_valid_o !== e.valid ||
            bus.pending_o !== e.pend || actMis !== e.mis) begin
            errors++;
            $display("[TB] FAIL vec%0d: got pc=%h plus=%h valid=%b pend=%b mis=%b, want pc=%h plus=%h valid=%b pend=%b mis=%b",
                     e.id, bus.pc_o, bus.pc_plus_o, bus.fetch_valid_o, bus.pending_o, actMis,
                     e.pc, e.pcPlus, e.valid, e.pend, e.mis);
        end
    endtask

    // Drive one cycle of inputs at a negedge and queue the state expected after the next posedge.
    task automatic applyStimulus(input logic stall, input logic ready, input logic exc,
                                 input logic br, input logic [31:0] bt,
                                 input logic jmp, input logic [31:0] jt,
                                 input logic [31:0] ePc, input logic eValid,
                                 input logic ePend, input logic eMis);
        exp_t e;
        bus.stall_i         = stall;
        bus.fetch_ready_i   = ready;
        bus.exc_i           = exc;
        bus.branch_i        = br;
        bus.branch_target_i = bt;
        bus.jump_i          = jmp;
        bus.jump_target_i   = jt;
        vecId++;
        e.id     = vecId;
        e.pc     = ePc;
        e.pcPlus = ePc + 32'd4;
        e.valid  = eValid;
        e.pend   = ePend;
        e.mis    = eMis;
        expQ.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    initial begin
        exp_t r;
        errors = 0;
        checks = 0;
        vecId  = 0;
        rst_n  = 1'b0;
        bus.stall_i = 0; bus.fetch_ready_i = 1; bus.exc_i = 0;
        bus.branch_i = 0; bus.branch_target_i = 0; bus.jump_i = 0; bus.jump_target_i = 0;
        #2;
        r.id = 0; r.pc = 32'h0; r.pcPlus = 32'h4; r.valid = 0; r.pend = 0; r.mis = 0;
        checkOutput(r);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Boot then sequential fetch
        applyStimulus(0,1,0, 0,32'h0,   0,32'h0,   32'h0000_0000,1,0,0);
        applyStimulus(0,1,0, 0,32'h0,   0,32'h0,   32'h0000_0004,1,0,0);
        applyStimulus(0,1,0, 0,32'h0,   0,32'h0,   32'h0000_0008,1,0,0);
        // Branch buffered while imem not ready
        applyStimulus(0,0,0, 1,32'h100, 0,32'h0,   32'h0000_0008,1,1,0);
        applyStimulus(0,0,0, 0,32'h0,   0,32'h0,   32'h0000_0008,1,1,0);
        applyStimulus(0,0,0, 0,32'h0,   0,32'h0,   32'h0000_0008,1,1,0);
        applyStimulus(0,1,0, 0,32'h0,   0,32'h0,   32'h0000_0100,1,0,0);
        // Weaker jump does not overwrite buffered branch
        applyStimulus(1,1,0, 1,32'h100, 0,32'h0,   32'h0000_0100,1,1,0);
        applyStimulus(1,1,0, 0,32'h0,   1,32'h200, 32'h0000_0100,1,1,0);
        applyStimulus(0,1,0, 0,32'h0,   0,32'h0,   32'h0000_0100,1,0,0);
        // Exception overwrites branch; later branch cannot displace it
        applyStimulus(1,1,0, 1,32'h40,  0,32'h0,   32'h0000_0100,1,1,0);
        applyStimulus(1,1,1, 0,32'h0,   0,32'h0,   32'h0000_0100,1,1,0);
        applyStimulus(1,1,0, 1,32'h60,  0,32'h0,   32'h0000_0100,1,1,0);
        applyStimulus(0,1,0, 0,32'h0,   1,32'h80,  32'h0000_0180,1,0,0);
        // Fresh jump with advance beats a buffered branch
        applyStimulus(1,1,0, 1,32'h200, 0,32'h0,   32'h0000_0180,1,1,0);
        applyStimulus(0,1,0, 0,32'h0,   1,32'h300, 32'h0000_0300,1,0,0);
        // Same-cycle priority
        applyStimulus(0,1,1, 1,32'h40,  1,32'h80,  32'h0000_0180,1,0,0);
        applyStimulus(0,1,0, 1,32'h44,  1,32'h80,  32'h0000_0044,1,0,0);
        // Wrap-around
        applyStimulus(0,1,0, 0,32'h0,   1,32'hFFFF_FFFC, 32'hFFFF_FFFC,1,0,0);
        applyStimulus(0,1,0, 0,32'h0,   0,32'h0,   32'h0000_0000,1,0,0);
        applyStimulus(0,1,0, 0,32'h0,   0,32'h0,   32'h0000_0004,1,0,0);
        // Misaligned jump target
        applyStimulus(0,1,0, 0,32'h0,   1,32'h102, ALIGN_PC,1,0,ALIGN_MIS);
        applyStimulus(0,1,0, 0,32'h0,   0,32'h0,   ALIGN_PC + 32'd4,1,0,0);
        // Buffered branch discarded by reset mid-operation
        applyStimulus(1,1,0, 1,32'h500, 0,32'h0,   ALIGN_PC + 32'd4,1,1,0);
        rst_n = 1'b0;
        bus.branch_i = 0; bus.stall_i = 0;
        #1;
        r.id = 100; r.pc = 32'h0; r.pcPlus = 32'h4; r.valid = 0; r.pend = 0; r.mis = 0;
        checkOutput(r);
        @(negedge clk);
        rst_n = 1'b1;
        // Redirect during BOOT is buffered
        applyStimulus(0,1,0, 0,32'h0,   1,32'h20,  32'h0000_0000,1,1,0);
        applyStimulus(0,1,0, 0,32'h0,   0,32'h0,   32'h0000_0020,1,0,0);
        applyStimulus(0,1,0, 0,32'h0,   0,32'h0,   32'h0000_0024,1,0,0);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d entries left, want 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
